regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port integer register file with write-through bypass and a per-register pending-write scoreboard, replacing the single-cycle register file for the pipelined core. Register 0 is hardwired to zero. An issue port marks destination registers busy and writeback clears them, so decode can stall on RAW hazards without a separate scoreboard block. All storage resets asynchronously to zero.

## Interface
Parameters:
- `XLEN`, 32, register width in bits.
- `NREGS`, 32, number of architectural registers; power of two, ≥ 2.
- `NRD`, 2, number of read ports, 1–4.
- `BYPASS`, 1, 1 = same-cycle write-to-read forwarding; 0 = none.
- Derived: `AW = $clog2(NREGS)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rd_addr` in `NRD×AW`: read addresses, one per port.
- `rd_data` out `NRD×XLEN`: read data, combinational.
- `rd_busy` out `NRD`: the addressed register has an outstanding write.
- `wr_en` in 1: writeback strobe.
- `wr_addr` in `AW`: writeback destination.
- `wr_data` in `XLEN`: writeback value.
- `iss_en` in 1: an instruction with a destination register is issued.
- `iss_addr` in `AW`: destination register of the issued instruction.
- `pend_cnt` out `AW+1`: number of registers currently marked busy.

## Operation
- Storage: `NREGS-1` flops of `XLEN` bits. Index 0 has no storage, always reads 0, and is never busy.
- Write: on `clk`↑ with `wr_en` and `wr_addr`≠0, `reg[wr_addr]` ← `wr_data`. Writes to 0 are discarded silently.
- Read, per port i: `rd_data[i]` = 0 if `rd_addr[i]`=0. Otherwise, when `BYPASS`=1, `wr_en` and `wr_addr`=`rd_addr[i]`, it is `wr_data`. Otherwise it is `reg[rd_addr[i]]`.
- Scoreboard: `busy[NREGS-1:1]`.
  - On `clk`↑, `iss_en` with `iss_addr`≠0 sets `busy[iss_addr]`.
  - On `clk`↑, `wr_en` with `wr_addr`≠0 clears `busy[wr_addr]`.
  - Same register hit by issue and writeback in one cycle: issue wins and busy stays 1, because the newer producer is still outstanding.
- `rd_busy[i]` = `busy[rd_addr[i]]`, with two exceptions:
  - It is 0 for address 0.
  - When `BYPASS`=1, it is also forced to 0 while a same-cycle writeback to that address is present, since the data is forwarded.
- `pend_cnt` is a registered population count of `busy`. It is updated incrementally by +1, −1 or 0 per cycle; the `busy` flag states are kept in sync with the count:
  - Setting an already-busy register does not increment.
  - Clearing a non-busy register does not decrement (a spurious writeback is tolerated).
  - Issue and clear of different registers in one cycle gives a net 0 change.
- No overflow is possible: the maximum count is `NREGS-1`, which fits in `AW+1` bits.

## Timing
- Reset (`rst_n`=0, asynchronous): all registers = 0, `busy` = 0, `pend_cnt` = 0. `rd_data` therefore reads 0 and `rd_busy` = 0.
- Reset deassertion mid-stream: the first edge with `rst_n`=1 accepts writes and issues normally. Writes or issues in flight during reset are lost.
- Read latency: 0 cycles, combinational from `rd_addr`, `wr_*` and state.
- Write latency: data is visible in `reg` from the cycle after the `wr_en` edge. With `BYPASS`=1 it is visible in the same cycle.
- Scoreboard: `rd_busy` rises in the cycle after `iss_en`. It falls in the `wr_en` cycle when `BYPASS`=1, and the cycle after when `BYPASS`=0.
- `pend_cnt` reflects `busy` with no extra lag (both update on the same edge).

## Structure
- Package `rv_pkg`: `XLEN` default, `REG_ZERO` constant (0), and typedef `reg_addr_t` (logic [4:0]) for the RV32I default.
- Sub-module `rf_scoreboard`: holds the busy vector and `pend_cnt`. It takes issue/clear inputs and the read addresses, and returns per-port raw busy bits. The bypass masking for `rd_busy` stays in the top level.
- Reuse the existing N:M one-hot decoder for the write and issue enables; the read paths use indexed muxes.

## Test plan
- Reset with registers preloaded: assert `rst_n`=0 mid-cycle → all ports read 0 and `pend_cnt`=0 immediately, without waiting for a clock edge.
- Write x5=0xDEADBEEF, then read x5 on every port next cycle → 0xDEADBEEF. Write x0=0x1234 → x0 reads 0.
- Same-cycle bypass, `BYPASS`=1: write x7=0xA5A5A5A5 with `rd_addr[1]`=7 → `rd_data[1]`=0xA5A5A5A5 that cycle. With `BYPASS`=0 → old value that cycle, new value next cycle.
- Scoreboard sequence:
  - Issue x3 → `rd_busy`=1 next cycle, `pend_cnt`=1.
  - Issue x3 again → count stays 1.
  - Writeback x3 → busy clears and `pend_cnt`=0.
  - Writeback to non-busy x9 → `pend_cnt` stays 0.
- Simultaneous issue and writeback on x4 while x4 is busy → x4 stays busy and `pend_cnt` is unchanged. Issue x6 plus writeback x4 in one cycle → x6 busy, x4 clear, net count 0.
- Fill: issue x1..x31 on consecutive cycles → `pend_cnt`=31 with no wrap; issue x0 → no change.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I register-file defaults (width, zero register, address type)
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef logic [4:0] reg_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-write busy flags with an incrementally maintained population count
//   iss_en/iss_addr : mark a destination busy      clr_en/clr_addr : clear on writeback
//   rd_addr         : per-port lookup addresses    raw_busy        : unmasked busy bit per port
//   pend_cnt        : number of busy registers
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    raw_busy,
    output logic [AW:0]       pend_cnt
);
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             set, clr, inc, dec;

    always_comb begin
        set = iss_en && iss_addr != '0;
        clr = clr_en && clr_addr != '0;
        // A same-register issue overrides the clear, so that clear never decrements
        inc = set && !busy_q[iss_addr];
        dec = clr && busy_q[clr_addr] && !(set && iss_addr == clr_addr);
        busy_d = busy_q;
        if (clr) busy_d[clr_addr] = 1'b0;
        if (set) busy_d[iss_addr] = 1'b1;
        busy_d[0] = 1'b0;
        cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
        for (int i = 0; i < NRD; i++)
            raw_busy[i] = busy_q[rd_addr[i*AW +: AW]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with x0 hardwired to zero, optional write-through bypass
// and a pending-write scoreboard
//   rd_addr/rd_data/rd_busy : NRD combinational read ports with busy status
//   wr_en/wr_addr/wr_data   : writeback port (also clears busy)
//   iss_en/iss_addr         : issue port (sets busy)
//   pend_cnt                : number of registers with an outstanding write
module regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN   = rv_pkg::XLEN,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [AW:0]         pend_cnt
);
    logic [XLEN-1:0] regs_q [NREGS-1:1];
    logic [XLEN-1:0] regs_d [NREGS-1:1];
    logic [NRD-1:0]  raw_busy;

    always_comb begin
        regs_d = regs_q;
        for (int r = 1; r < NREGS; r++)
            if (wr_en && wr_addr == AW'(r)) regs_d[r] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(.NREGS(NREGS), .NRD(NRD)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .clr_en   (wr_en),
        .clr_addr (wr_addr),
        .rd_addr  (rd_addr),
        .raw_busy (raw_busy),
        .pend_cnt (pend_cnt)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] d;
            logic            fwd;
            a   = rd_addr[i*AW +: AW];
            d   = '0;
            for (int r = 1; r < NREGS; r++)
                if (a == AW'(r)) d = regs_q[r];
            fwd = (BYPASS != 0) && wr_en && wr_addr == a && a != REG_ZERO[AW-1:0];
            rd_data[i*XLEN +: XLEN] = fwd ? wr_data : d;
            rd_busy[i] = raw_busy[i] && a != '0 && !fwd;
        end
    end
endmodule
